// File: rtl/mips_mem_pkg.sv
// Shared constants and FSM state type for the data-memory dump reader.
// Used by mem_dump_reader and dump_checksum_acc.
package mips_mem_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    OUT,
    DONE
  } dump_state_t;

endpackage

// File: rtl/dump_checksum_acc.sv
// Running modulo-2^DATA_W sum of dumped words.
// Instantiated by mem_dump_reader only when DUMP_CHECKSUM_EN is defined.
module dump_checksum_acc #(
  parameter int DATA_W = mips_mem_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              add_en,
  input  logic [DATA_W-1:0] add_val,
  output logic [DATA_W-1:0] sum
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum <= '0;
    end else if (clear) begin
      sum <= '0;
    end else if (add_en) begin
      sum <= sum + add_val;
    end
  end

endmodule

// File: rtl/mem_dump_reader.sv
// Streams a window of data memory out over a valid/ready port.
// Optional running checksum enabled with the DUMP_CHECKSUM_EN macro.
module mem_dump_reader #(
  parameter int ADDR_W = mips_mem_pkg::ADDR_W,
  parameter int DATA_W = mips_mem_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  import mips_mem_pkg::*;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

  dump_state_t state;
  dump_state_t state_n;

  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   remaining;
  logic              accept;
  logic              empty_req;
  logic              xfer;
  logic              last;

  assign accept    = (state == IDLE) && start;
  assign empty_req = (word_count == '0);
  assign xfer      = (state == OUT) && out_ready;
  assign last      = (remaining == CNT_ONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = empty_req ? DONE : READ;
        end
      end
      READ: state_n = WAIT;
      WAIT: state_n = OUT;
      OUT: begin
        if (out_ready) begin
          state_n = last ? DONE : READ;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    mem_rd_en = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      READ: begin
        mem_rd_en = 1'b1;
        busy      = 1'b1;
      end
      WAIT: busy = 1'b1;
      OUT: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      DONE: done = 1'b1;
      default: begin
        mem_rd_en = 1'b0;
      end
    endcase
  end

  // Address and count only move on an accepted start or a completed transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr      <= '0;
      remaining <= '0;
    end else if (accept && !empty_req) begin
      addr      <= base_addr;
      remaining <= word_count;
    end else if (xfer && !last) begin
      addr      <= addr + ADDR_ONE;
      remaining <= remaining - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data <= '0;
      out_addr <= '0;
    end else if (state == WAIT) begin
      out_data <= mem_rd_data;
      out_addr <= addr;
    end
  end

  assign mem_rd_addr = addr;

`ifdef DUMP_CHECKSUM_EN
  dump_checksum_acc #(
    .DATA_W (DATA_W)
  ) u_acc (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .add_en  (xfer),
    .add_val (out_data),
    .sum     (checksum)
  );
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_mem_dump_reader.sv
// Directed self-checking bench for mem_dump_reader.
// Checksum expectations follow DUMP_CHECKSUM_EN.
module tb_mem_dump_reader;

  localparam int AW = 10;
  localparam int DW = 32;

`ifdef DUMP_CHECKSUM_EN
  localparam logic [DW-1:0] SUM7 = 32'd45;
  localparam logic [DW-1:0] SUM2 = 32'd6;
`else
  localparam logic [DW-1:0] SUM7 = 32'd0;
  localparam logic [DW-1:0] SUM2 = 32'd0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   word_count = '0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          busy;
  logic          done;
  logic [DW-1:0] checksum;

  logic [DW-1:0] mem [0:1023];
  logic [DW-1:0] exp_seq [0:6];

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
  end

  mem_dump_reader #(
    .ADDR_W (AW),
    .DATA_W (DW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base_addr   (base_addr),
    .word_count  (word_count),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_addr    (out_addr),
    .busy        (busy),
    .done        (done),
    .checksum    (checksum)
  );

  task automatic pulse_start(input logic [AW-1:0] b,
                             input logic [AW:0] c);
    start      = 1'b1;
    base_addr  = b;
    word_count = c;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({out_valid, mem_rd_en, busy, done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctrl got %b want 0000",
               {out_valid, mem_rd_en, busy, done});
    end
    n_checks++;
    if (out_data !== '0 || out_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_out got %h/%h want 0/0", out_data, out_addr);
    end
    n_checks++;
    if (mem_rd_addr !== '0 || checksum !== '0) begin
      n_fail++;
      $display("FAIL reset_addr_sum got %h/%h want 0/0",
               mem_rd_addr, checksum);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_busy got %b want 0", busy);
    end
  endtask

  task automatic test_basic();
    int idx = 0;
    int dones = 0;
    int end_cyc = -1;
    out_ready = 1'b1;
    pulse_start(10'd0, 11'd7);
    n_checks++;
    if (mem_rd_en !== 1'b1 || mem_rd_addr !== 10'd0) begin
      n_fail++;
      $display("FAIL first_read got en=%b addr=%0d want en=1 addr=0",
               mem_rd_en, mem_rd_addr);
    end
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (out_valid && out_ready) begin
        n_checks++;
        if (idx > 6 || out_data !== exp_seq[idx] ||
            out_addr !== AW'(idx)) begin
          n_fail++;
          $display("FAIL basic_word%0d got %0d@%0d", idx,
                   out_data, out_addr);
        end
        idx++;
      end
      if (done) begin
        dones++;
        end_cyc = cyc;
        n_checks++;
        if (busy !== 1'b0) begin
          n_fail++;
          $display("FAIL done_busy got %b want 0", busy);
        end
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (idx != 7 || dones != 1) begin
      n_fail++;
      $display("FAIL basic_count got %0d words %0d done want 7/1",
               idx, dones);
    end
    n_checks++;
    if (end_cyc != 21) begin
      n_fail++;
      $display("FAIL basic_latency got %0d want 21", end_cyc);
    end
    n_checks++;
    if (checksum !== SUM7) begin
      n_fail++;
      $display("FAIL basic_sum got %0d want %0d", checksum, SUM7);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || checksum !== SUM7) begin
      n_fail++;
      $display("FAIL done_pulse got done=%b sum=%0d want 0/%0d",
               done, checksum, SUM7);
    end
  endtask

  task automatic test_stall();
    int idx = 0;
    int dones = 0;
    bit stalled = 1'b0;
    out_ready = 1'b1;
    pulse_start(10'd0, 11'd7);
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (out_valid && out_addr == 10'd2 && !stalled) begin
        stalled   = 1'b1;
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          n_checks++;
          if (out_valid !== 1'b1 || out_data !== 32'd1 ||
              out_addr !== 10'd2 || mem_rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_hold%0d got v=%b d=%0d a=%0d rd=%b",
                     s, out_valid, out_data, out_addr, mem_rd_en);
          end
        end
        out_ready = 1'b1;
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (idx > 6 || out_data !== exp_seq[idx] ||
            out_addr !== AW'(idx)) begin
          n_fail++;
          $display("FAIL stall_word%0d got %0d@%0d", idx,
                   out_data, out_addr);
        end
        idx++;
      end
      if (done) begin
        dones++;
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (idx != 7 || dones != 1 || !stalled) begin
      n_fail++;
      $display("FAIL stall_count got %0d words %0d done want 7/1",
               idx, dones);
    end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    logic [AW-1:0] exp_a [0:3];
    int n_rd = 0;
    int dones = 0;
    exp_a[0] = 10'd1022;
    exp_a[1] = 10'd1023;
    exp_a[2] = 10'd0;
    exp_a[3] = 10'd1;
    out_ready = 1'b1;
    pulse_start(10'd1022, 11'd4);
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (mem_rd_en) begin
        n_checks++;
        if (n_rd > 3 || mem_rd_addr !== exp_a[n_rd]) begin
          n_fail++;
          $display("FAIL wrap_rd%0d got %0d", n_rd, mem_rd_addr);
        end
        n_rd++;
      end
      if (out_valid && out_addr == 10'd1023) begin
        n_checks++;
        if (out_data !== 32'h5a) begin
          n_fail++;
          $display("FAIL wrap_data got %h want 5a", out_data);
        end
      end
      if (done) begin
        dones++;
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (n_rd != 4 || dones != 1) begin
      n_fail++;
      $display("FAIL wrap_count got %0d reads %0d done want 4/1",
               n_rd, dones);
    end
    @(negedge clk);
  endtask

  task automatic test_zero();
    pulse_start(10'd3, 11'd0);
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 ||
        mem_rd_en !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_done got d=%b b=%b rd=%b v=%b want 1000",
               done, busy, mem_rd_en, out_valid);
    end
    n_checks++;
    if (checksum !== '0) begin
      n_fail++;
      $display("FAIL zero_sum got %0d want 0", checksum);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || mem_rd_en !== 1'b0 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL zero_quiet%0d got d=%b rd=%b v=%b want 000",
                 c, done, mem_rd_en, out_valid);
      end
    end
  endtask

  task automatic test_reset_mid();
    int xfers = 0;
    int idx = 0;
    int dones = 0;
    out_ready = 1'b1;
    pulse_start(10'd0, 11'd7);
    for (int cyc = 0; cyc < 40 && xfers < 3; cyc++) begin
      if (out_valid && out_ready) xfers++;
      @(negedge clk);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, mem_rd_en, busy, done} !== 4'b0000 ||
        out_data !== '0 || out_addr !== '0 ||
        mem_rd_addr !== '0 || checksum !== '0) begin
      n_fail++;
      $display("FAIL abort_zero got ctl=%b d=%0d a=%0d ra=%0d s=%0d",
               {out_valid, mem_rd_en, busy, done}, out_data,
               out_addr, mem_rd_addr, checksum);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_done%0d got 1 want 0", c);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    pulse_start(10'd0, 11'd2);
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (out_valid && out_ready) begin
        n_checks++;
        if (idx > 1 || out_data !== exp_seq[idx]) begin
          n_fail++;
          $display("FAIL fresh_word%0d got %0d", idx, out_data);
        end
        idx++;
      end
      if (done) begin
        dones++;
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (idx != 2 || dones != 1 || checksum !== SUM2) begin
      n_fail++;
      $display("FAIL fresh_count got %0d/%0d sum=%0d want 2/1/%0d",
               idx, dones, checksum, SUM2);
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_start();
    int idx = 0;
    int n_rd = 0;
    int dones = 0;
    out_ready = 1'b1;
    pulse_start(10'd0, 11'd7);
    for (int cyc = 0; cyc < 60; cyc++) begin
      start      = (cyc == 4);
      base_addr  = (cyc == 4) ? 10'd5 : 10'd0;
      word_count = (cyc == 4) ? 11'd2 : 11'd0;
      if (mem_rd_en) begin
        n_checks++;
        if (mem_rd_addr !== AW'(n_rd)) begin
          n_fail++;
          $display("FAIL ignore_rd%0d got %0d", n_rd, mem_rd_addr);
        end
        n_rd++;
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (idx > 6 || out_data !== exp_seq[idx] ||
            out_addr !== AW'(idx)) begin
          n_fail++;
          $display("FAIL ignore_word%0d got %0d@%0d", idx,
                   out_data, out_addr);
        end
        idx++;
      end
      if (done) begin
        dones++;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    n_checks++;
    if (idx != 7 || n_rd != 7 || dones != 1 || checksum !== SUM7) begin
      n_fail++;
      $display("FAIL ignore_count got %0d/%0d/%0d sum=%0d",
               idx, n_rd, dones, checksum);
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hdead0000 + i;
    mem[0] = 32'd4;
    mem[1] = 32'd2;
    mem[2] = 32'd1;
    mem[3] = 32'd7;
    mem[4] = 32'd9;
    mem[5] = 32'd8;
    mem[6] = 32'd14;
    mem[1022] = 32'ha5;
    mem[1023] = 32'h5a;
    for (int i = 0; i < 7; i++) exp_seq[i] = mem[i];

    test_reset();
    test_basic();
    test_stall();
    test_wrap();
    test_zero();
    test_reset_mid();
    test_ignore_start();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_dump_reader.md
MEM_DUMP_READER -- requirements
Module: mem_dump_reader

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width of the data memory.
REQ-002 Parameter DATA_W, default 32, data word width.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle request to begin a dump.
REQ-006 base_addr  input  ADDR_W  first word address, sampled on accepted start.
REQ-007 word_count  input  ADDR_W+1  words to dump (0..1024), sampled on accepted start.
REQ-008 mem_rd_en  output  1  synchronous read strobe to data memory.
REQ-009 mem_rd_addr  output  ADDR_W  read word address.
REQ-010 mem_rd_data  input  DATA_W  read data, valid exactly one cycle after mem_rd_en.
REQ-011 out_valid / out_ready  output / input  1 / 1  stream handshake; a transfer occurs when both are high on a clk edge.
REQ-012 out_data / out_addr  output  DATA_W / ADDR_W  dumped word and its address.
REQ-013 busy  output  1  high from accepted start until done.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 checksum  output  DATA_W  running sum (see Configuration).

Function
REQ-016 FSM states: IDLE, READ, WAIT, OUT, DONE.
REQ-017 IDLE: start with word_count!=0 latches base_addr/word_count, enters READ; start with word_count==0 enters DONE directly, no memory read, no out_valid.
REQ-018 start while not IDLE is ignored; latched parameters are unchanged.
REQ-019 READ: mem_rd_en=1, mem_rd_addr=current address for exactly one cycle; next state WAIT.
REQ-020 WAIT: mem_rd_data registered into out_data, current address into out_addr; out_valid rises next cycle; next state OUT.
REQ-021 OUT: out_valid, out_data, out_addr held stable until the transfer; no memory read issued while waiting.
REQ-022 On transfer: remaining==1 -> DONE; else address increments, remaining decrements, -> READ.
REQ-023 Address increment wraps modulo 2^ADDR_W (1023 -> 0).
REQ-024 DONE: done=1 for one cycle, busy=0 the same cycle, -> IDLE.
REQ-025 Minimum throughput one word per 3 cycles; first mem_rd_en one cycle after accepted start.
REQ-026 mem_rd_en is 0 in every state other than READ.

Reset
REQ-027 rst low asynchronously forces IDLE; out_valid, mem_rd_en, busy, done = 0; out_data, out_addr, mem_rd_addr, checksum = 0.
REQ-028 Reset mid-transfer aborts without a done pulse; the next start after rst release behaves as from power-up.

Configuration
REQ-029 Macro DUMP_CHECKSUM_EN defined: checksum clears to 0 on accepted start, adds out_data on each transfer modulo 2^DATA_W, holds after done until the next accepted start.
REQ-030 Macro undefined: checksum tied to 0, no accumulator logic synthesized; all other behaviour identical.

Structure
REQ-031 Shared package mips_mem_pkg holds ADDR_W/DATA_W constants and the dump FSM state typedef.
REQ-032 Accumulator is a sub-module dump_checksum_acc, instantiated only under DUMP_CHECKSUM_EN.

Verification (memory preloaded words 0..6 = 4,2,1,7,9,8,14)
REQ-033 start, base=0, count=7, out_ready=1 -> out_data 4,2,1,7,9,8,14 with out_addr 0..6, one done pulse, checksum=45 (macro on).
REQ-034 out_ready low 5 cycles while word at addr 2 is presented -> out_data holds 1, no mem_rd_en during the stall, sequence completes unchanged.
REQ-035 base=1022, count=4 -> mem_rd_addr sequence 1022, 1023, 0, 1.
REQ-036 count=0 -> done one cycle after start, mem_rd_en and out_valid never asserted.
REQ-037 rst low after third transfer of a count=7 dump -> outputs 0 immediately, no done; fresh start base=0 count=2 yields 4,2.
REQ-038 start pulsed while busy with base=5 -> ignored; original dump addresses and count unchanged.
